spn_req_arbiter: RTL

- Round-robin scheduler that shares one SPN encrypt/decrypt core among NUM_REQ independent requesters.
- Each request is accepted through a valid/ready handshake and issued to the core as a single-cycle opcode pulse.
- The core's registered result is captured and returned on one shared response channel, tagged with the requester ID, with backpressure.
- Sits between client logic and the core; drives the core's opcode/data/key inputs and consumes its data_out/valid outputs.

---
 rtl/spn_req_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spn_req_arbiter.sv
// Round-robin front end for a shared SPN encrypt/decrypt core.
// Accepts one request at a time from NUM_REQ requesters, issues it to the
// core as a single-cycle opcode pulse, captures the core's registered result
// and returns it on a shared, backpressured response channel tagged with the
// requester index.
module spn_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic [32*NUM_REQ-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            core_opcode,
    output logic [15:0]           core_data_in,
    output logic [31:0]           core_key,
    input  logic [15:0]           core_data_out,
    input  logic [1:0]            core_valid,
    output logic [15:0]           op_count
);

    // Request slots padded to the full tag range so a tag-wide index is always in range.
    localparam int NSLOT = 2 ** ID_W;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;     // last granted requester
    logic              lat_op;     // latched operation: 0 encrypt, 1 decrypt
    logic [ID_W-1:0]   lat_id;     // latched requester index

    logic [NSLOT-1:0]  valid_ext;
    logic [NSLOT-1:0]  op_ext;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    int                cand;
    logic [ID_W-1:0]   cand_id;
    logic [15:0]       sel_data;
    logic [31:0]       sel_key;
    logic              sel_op;

    assign valid_ext = NSLOT'(req_valid);
    assign op_ext    = NSLOT'(req_op);

    // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        cand_id     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (!grant_found && valid_ext[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // Field mux for the granted requester and the combinational accept strobe.
    always_comb begin
        sel_data  = req_data[16*int'(grant_id) +: 16];
        sel_key   = req_key[32*int'(grant_id) +: 32];
        sel_op    = op_ext[grant_id];
        req_ready = '0;
        if (state == ST_IDLE && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    // Sequencer: accept, pulse the core, capture its result, hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            lat_op       <= 1'b0;
            lat_id       <= '0;
            core_opcode  <= OP_IDLE;
            core_data_in <= '0;
            core_key     <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            op_count     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        lat_op       <= sel_op;
                        lat_id       <= grant_id;
                        rr_ptr       <= grant_id;
                        core_data_in <= sel_data;
                        core_key     <= sel_key;
                        core_opcode  <= sel_op ? OP_DEC : OP_ENC;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Opcode is a one-cycle pulse; data and key stay on the core inputs.
                    core_opcode <= OP_IDLE;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    rsp_data  <= core_data_out;
                    rsp_id    <= lat_id;
                    rsp_err   <= (core_valid != (lat_op ? OP_DEC : OP_ENC));
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    core_opcode <= OP_IDLE;
                    rsp_valid   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
